// File: rtl/cpu_pkg.sv
// Shared CPU types and default widths: response-owner encoding plus
// the address/data widths used by the memory-side blocks.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 32;
  localparam int unsigned CPU_DATA_W = 32;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported SRAM between instruction fetch and the LSU, one access per cycle.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = CPU_ADDR_W,
  parameter int unsigned DATA_W     = CPU_DATA_W,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  output logic                if_rsp_valid,
  output logic [DATA_W-1:0]   if_rsp_rdata,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic                d_req_we,
  input  logic [DATA_W/8-1:0] d_req_wstrb,
  input  logic [DATA_W-1:0]   d_req_wdata,
  output logic                d_rsp_valid,
  output logic [DATA_W-1:0]   d_rsp_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // Handshake: a request transfers in the cycle where valid && ready; the
  // requester holds valid and payload until then. Responses are 1 cycle later
  // and cannot be stalled.
  logic       grant_if;
  logic       grant_d;
  logic       force_if;
  rsp_owner_e owner_q, owner_d;
  logic       rsp_we_q, rsp_we_d;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  logic [CNT_W-1:0] starve_q, starve_d;

  // Counts contested cycles fetch has lost; at the limit fetch wins the next one.
  always_comb begin
    force_if = (starve_q == CNT_W'(STARVE_MAX));
    starve_d = starve_q;
    if (grant_if) begin
      starve_d = '0;
    end else if (if_req_valid && grant_d) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Without the guard fetch is never forced (STARVE_MAX is always >= 1).
  assign force_if = (STARVE_MAX == 0);
`endif

  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (!rst) begin
      if (if_req_valid && d_req_valid) begin
        grant_if = force_if;
        grant_d  = !force_if;
      end else begin
        grant_if = if_req_valid;
        grant_d  = d_req_valid;
      end
    end
  end

  assign if_req_ready = grant_if;
  assign d_req_ready  = grant_d;

  always_comb begin
    mem_en    = grant_if || grant_d;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    if (grant_d) begin
      mem_we    = d_req_we;
      mem_addr  = d_req_addr;
      mem_wstrb = d_req_wstrb;
      mem_wdata = d_req_wdata;
    end else if (grant_if) begin
      mem_addr  = if_req_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q  <= RSP_NONE;
      rsp_we_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      rsp_we_q <= rsp_we_d;
    end
  end

  // The owner of next cycle's response is whoever is granted now.
  always_comb begin
    owner_d      = RSP_NONE;
    rsp_we_d     = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_rdata = '0;
    d_rsp_valid  = 1'b0;
    d_rsp_rdata  = '0;
    if (grant_if) begin
      owner_d  = RSP_IF;
    end else if (grant_d) begin
      owner_d  = RSP_D;
      rsp_we_d = d_req_we;
    end
    // An access in flight when reset arrives is dropped.
    if (!rst) begin
      case (owner_q)
        RSP_IF: begin
          if_rsp_valid = 1'b1;
          if_rsp_rdata = mem_rdata;
        end
        RSP_D: begin
          d_rsp_valid = 1'b1;
          d_rsp_rdata = rsp_we_q ? '0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model (priority rules + word memory).
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = DATA_W / 8;
  localparam int STARVE_MAX = 4;
  localparam int MEM_WORDS  = 256;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              if_req_valid = 1'b0;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_req_addr = '0;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_rdata;
  logic              d_req_valid = 1'b0;
  logic              d_req_ready;
  logic [ADDR_W-1:0] d_req_addr = '0;
  logic              d_req_we = 1'b0;
  logic [STRB_W-1:0] d_req_wstrb = '0;
  logic [DATA_W-1:0] d_req_wdata = '0;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rsp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  int starve_cnt = 0;
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic [DATA_W-1:0] exp_if_q[$];
  logic [DATA_W-1:0] exp_d_q[$];

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_rdata(if_rsp_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_wstrb(d_req_wstrb), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // ---------------- clock / SRAM environment ----------------
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(int i);
    return (DATA_W'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  logic [DATA_W-1:0] sram [MEM_WORDS];
  bit sram_init_done = 1'b0;
  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int i = 0; i < MEM_WORDS; i++) sram[i] <= init_word(i);
      sram_init_done <= 1'b1;
      mem_rdata <= $urandom;
    end else if (mem_en && !mem_we) begin
      mem_rdata <= sram[mem_addr[9:2]];
    end else begin
      // garbage on the read bus whenever no read was issued
      mem_rdata <= $urandom;
      if (mem_en) begin
        for (int b = 0; b < STRB_W; b++)
          if (mem_wstrb[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- reference model ----------------
  // 0 = no grant, 1 = fetch, 2 = data
  function automatic int model_pick(bit ifv, bit dv);
    if (ifv && dv) return (GUARD && starve_cnt == STARVE_MAX) ? 1 : 2;
    if (dv) return 2;
    if (ifv) return 1;
    return 0;
  endfunction

  function automatic void model_write(logic [ADDR_W-1:0] a, logic [STRB_W-1:0] s,
                                      logic [DATA_W-1:0] d);
    for (int b = 0; b < STRB_W; b++)
      if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    starve_cnt = 0;
    exp_if_q.delete();
    exp_d_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h20;
    d_req_valid = 1'b1; d_req_addr = 32'h24; d_req_we = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({if_req_ready, d_req_ready, mem_en, if_rsp_valid, d_rsp_valid} !== 5'b0) begin
        errors++;
        $display("FAIL reset_outputs cyc%0d: got ready_if/ready_d/mem_en/rsp_if/rsp_d=%b expected 00000",
                 c, {if_req_ready, d_req_ready, mem_en, if_rsp_valid, d_rsp_valid});
      end
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_first_grant: got ready_if/ready_d/rsp_if/rsp_d=%b expected 0100",
               {if_req_ready, d_req_ready, if_rsp_valid, d_rsp_valid});
    end
    tick();
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_fetch_alone();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h10;
    d_req_wstrb = 4'hF; d_req_wdata = 32'h0050_0093;
    model_write(32'h10, 4'hF, 32'h0050_0093);
    tick();
    d_req_valid = 1'b0; d_req_we = 1'b0;
    tick();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    @(negedge clk);
    checks++;
    if ({if_req_ready, mem_en, mem_we, mem_wstrb, mem_addr} !== {3'b110, 4'h0, 32'h10}) begin
      errors++;
      $display("FAIL fetch_issue: got ready=%b en=%b we=%b strb=%h addr=%h expected 1 1 0 0 00000010",
               if_req_ready, mem_en, mem_we, mem_wstrb, mem_addr);
    end
    tick();
    if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rsp_valid, if_rsp_rdata, d_rsp_valid} !== {1'b1, 32'h0050_0093, 1'b0}) begin
      errors++;
      $display("FAIL fetch_rsp: got if_valid=%b rdata=%h d_valid=%b expected 1 00500093 0",
               if_rsp_valid, if_rsp_rdata, d_rsp_valid);
    end
    tick();
  endtask

  task automatic test_store_load();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 32'h100;
    d_req_wstrb = 4'hF; d_req_wdata = 32'h0;
    tick();
    d_req_wstrb = 4'b0011; d_req_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if ({d_req_ready, mem_we, mem_wstrb, mem_wdata, mem_addr} !== {2'b11, 4'b0011, 32'hDEAD_BEEF, 32'h100}) begin
      errors++;
      $display("FAIL store_issue: got ready=%b we=%b strb=%b wdata=%h addr=%h expected 1 1 0011 deadbeef 00000100",
               d_req_ready, mem_we, mem_wstrb, mem_wdata, mem_addr);
    end
    tick();
    d_req_we = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rsp_valid, d_rsp_rdata, d_req_ready, mem_we} !== {1'b1, 32'h0, 2'b10}) begin
      errors++;
      $display("FAIL store_ack: got valid=%b rdata=%h next_ready=%b next_we=%b expected 1 00000000 1 0",
               d_rsp_valid, d_rsp_rdata, d_req_ready, mem_we);
    end
    tick();
    d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({d_rsp_valid, d_rsp_rdata, if_rsp_valid} !== {1'b1, 32'h0000_BEEF, 1'b0}) begin
      errors++;
      $display("FAIL load_after_store: got valid=%b rdata=%h if_valid=%b expected 1 0000beef 0",
               d_rsp_valid, d_rsp_rdata, if_rsp_valid);
    end
    ref_mem[64] = 32'h0000_BEEF;
    tick();
  endtask

  task automatic test_contention();
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h100;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({if_req_ready, d_req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL contention_cyc%0d: got ready_if/ready_d=%b expected 01", c, {if_req_ready, d_req_ready});
      end
      tick();
    end
    d_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_req_ready, d_req_ready, d_rsp_valid, d_rsp_rdata} !== {3'b101, 32'h0000_BEEF}) begin
      errors++;
      $display("FAIL contention_release: got ready_if=%b ready_d=%b d_rsp=%b rdata=%h expected 1 0 1 0000beef",
               if_req_ready, d_req_ready, d_rsp_valid, d_rsp_rdata);
    end
    tick();
    if_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    bit exp_if;
    do_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h104;
    for (int c = 0; c < 3 * (STARVE_MAX + 1); c++) begin
      exp_if = GUARD && ((c % (STARVE_MAX + 1)) == STARVE_MAX);
      @(negedge clk);
      checks++;
      if ({if_req_ready, d_req_ready} !== {exp_if, !exp_if}) begin
        errors++;
        $display("FAIL starvation_cyc%0d: got ready_if/ready_d=%b expected %b",
                 c, {if_req_ready, d_req_ready}, {exp_if, !exp_if});
      end
      tick();
    end
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_midflight_reset();
    if_req_valid = 1'b1; if_req_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (if_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midflight_accept: got ready=%b expected 1", if_req_ready);
    end
    tick();
    rst = 1'b1;
    if_req_valid = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checks++;
      if ({if_rsp_valid, if_rsp_rdata} !== {1'b0, 32'h0}) begin
        errors++;
        $display("FAIL midflight_rsp_n%0d: got valid=%b rdata=%h expected 0 00000000", c, if_rsp_valid, if_rsp_rdata);
      end
      tick();
      rst = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    int pick;
    logic              exp_ifv, exp_dv;
    logic [DATA_W-1:0] exp_ifd, exp_dd;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_addr;
    logic [STRB_W-1:0] exp_strb;
    logic [DATA_W-1:0] exp_wdata;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      pick = model_pick(if_req_valid, d_req_valid);
      exp_ifv = (exp_if_q.size() != 0);
      exp_ifd = exp_ifv ? exp_if_q.pop_front() : '0;
      exp_dv  = (exp_d_q.size() != 0);
      exp_dd  = exp_dv ? exp_d_q.pop_front() : '0;
      exp_we = 1'b0; exp_addr = '0; exp_strb = '0; exp_wdata = '0;
      if (pick == 1) begin
        exp_addr = if_req_addr;
      end else if (pick == 2) begin
        exp_we = d_req_we; exp_addr = d_req_addr; exp_strb = d_req_wstrb; exp_wdata = d_req_wdata;
      end
      checks++;
      if ({if_rsp_valid, if_rsp_rdata, d_rsp_valid, d_rsp_rdata} !== {exp_ifv, exp_ifd, exp_dv, exp_dd}) begin
        errors++;
        $display("FAIL rand_rsp cyc%0d: got if=%b/%h d=%b/%h expected if=%b/%h d=%b/%h", c,
                 if_rsp_valid, if_rsp_rdata, d_rsp_valid, d_rsp_rdata, exp_ifv, exp_ifd, exp_dv, exp_dd);
      end
      checks++;
      if ({if_req_ready, d_req_ready, mem_en} !== {pick == 1, pick == 2, pick != 0}) begin
        errors++;
        $display("FAIL rand_grant cyc%0d: got ready_if/ready_d/en=%b expected %b", c,
                 {if_req_ready, d_req_ready, mem_en}, {pick == 1, pick == 2, pick != 0});
      end
      checks++;
      if ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== {exp_we, exp_addr, exp_strb, exp_wdata}) begin
        errors++;
        $display("FAIL rand_mem cyc%0d: got we=%b addr=%h strb=%h wdata=%h expected %b %h %h %h", c,
                 mem_we, mem_addr, mem_wstrb, mem_wdata, exp_we, exp_addr, exp_strb, exp_wdata);
      end
      // advance the model by the transaction it just predicted
      if (pick == 1) begin
        exp_if_q.push_back(ref_mem[if_req_addr[9:2]]);
        starve_cnt = 0;
      end else if (pick == 2) begin
        if (d_req_we) begin
          model_write(d_req_addr, d_req_wstrb, d_req_wdata);
          exp_d_q.push_back('0);
        end else begin
          exp_d_q.push_back(ref_mem[d_req_addr[9:2]]);
        end
        if (if_req_valid) starve_cnt++;
      end
      tick();
      if (!if_req_valid || pick == 1) begin
        if_req_valid = ($urandom_range(0, 3) != 0);
        if_req_addr  = ADDR_W'($urandom_range(0, 1023));
      end
      if (!d_req_valid || pick == 2) begin
        d_req_valid = ($urandom_range(0, 2) != 0);
        d_req_addr  = ADDR_W'($urandom_range(0, 1023));
        d_req_we    = 1'($urandom_range(0, 1));
        d_req_wstrb = STRB_W'($urandom_range(0, 15));
        d_req_wdata = $urandom;
      end
    end
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = init_word(i);
    tick();
    test_reset();
    test_fetch_alone();
    test_store_load();
    test_contention();
    test_starvation();
    test_midflight_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
